// File: rtl/i2s_msb_receiver_if.sv
// i2s_msb_receiver_if: sample stream from the I2S receiver FIFO head to the USB packetiser.
interface i2s_msb_receiver_if #(
    parameter int SAMPLE_BITS = 24
);
    logic [SAMPLE_BITS-1:0] sample_o;
    logic                   channel_o;
    logic                   valid_o;
    logic                   ready_i;
    modport master (output sample_o, channel_o, valid_o, input ready_i);
    modport slave (input sample_o, channel_o, valid_o, output ready_i);
endinterface

// File: rtl/i2s_msb_receiver.sv
// i2s_msb_receiver: MSB-justified serial deserialiser feeding a small sample FIFO.
// Optional: define I2S_RX_OVERWRITE_EN so a push into a full FIFO replaces the oldest entry.
module i2s_msb_receiver #(
    parameter int SAMPLE_BITS     = 24,
    parameter int SLOT_BITS       = 32,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               i2s_data_i,
    input  logic               i2s_bclk_i,
    input  logic               i2s_lrclk_i,
    input  logic               i2s_running_i,
    i2s_msb_receiver_if.master out_if,
    output logic               synced_o,
    output logic               frame_err_o,
    output logic               overflow_o
);
    localparam int CW = $clog2(SLOT_BITS) + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam logic [CW-1:0] LAST_BIT = CW'(SAMPLE_BITS - 1);
    localparam logic [CW-1:0] SLOT_END = CW'(SLOT_BITS);
`ifdef I2S_RX_OVERWRITE_EN
    localparam logic OVERWRITE = 1'b1;
`else
    localparam logic OVERWRITE = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, HUNT, SHIFT, PAD} state_t;
    state_t                   state_q;
    logic                     bclk_q, lr_q, chan_q, synced_q, err_q, ovf_q;
    logic [CW-1:0]            bit_cnt_q;
    logic [SAMPLE_BITS-1:0]   shift_q;
    logic [FIFO_DEPTH_BITS:0] wr_q, rd_q;
    logic [SAMPLE_BITS:0]     mem_q [DEPTH];
    logic [SAMPLE_BITS:0]     hold_q, head, push_word;
    logic                     rise, lr_edge, push, pop, empty, full, drop, write, rd_adv;
    // Bit-clock edge detection, sample-completion push and FIFO pointer decisions.
    always_comb begin
        rise      = i2s_bclk_i && !bclk_q;
        lr_edge   = rise && (i2s_lrclk_i != lr_q);
        push      = i2s_running_i && state_q == SHIFT && rise && !lr_edge && bit_cnt_q == LAST_BIT;
        push_word = {chan_q, shift_q[SAMPLE_BITS-2:0], i2s_data_i};
        empty     = wr_q == rd_q;
        full      = wr_q == {~rd_q[FIFO_DEPTH_BITS], rd_q[FIFO_DEPTH_BITS-1:0]};
        pop       = !empty && out_if.ready_i;
        drop      = push && full && !pop;
        write     = push && (!drop || OVERWRITE);
        rd_adv    = pop || (drop && OVERWRITE);
        head      = mem_q[rd_q[FIFO_DEPTH_BITS-1:0]];
    end
    assign out_if.valid_o = !empty;
    assign {out_if.channel_o, out_if.sample_o} = empty ? hold_q : head;
    assign synced_o    = synced_q;
    assign frame_err_o = err_q;
    assign overflow_o  = ovf_q;
    // bclk history and the lrclk value seen at the previous rising bclk.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bclk_q <= 1'b0;
            lr_q   <= 1'b0;
        end else begin
            bclk_q <= i2s_bclk_i;
            if (rise) lr_q <= i2s_lrclk_i;
        end
    end
    // Slot framing: hunt for a word-select edge, shift the sample, then pad to the next edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            chan_q    <= 1'b0;
            synced_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (!i2s_running_i) begin
                state_q  <= IDLE;
                synced_q <= 1'b0;
            end else if (state_q == IDLE) begin
                state_q <= HUNT;
            end else if (lr_edge) begin
                err_q     <= state_q == SHIFT;
                shift_q   <= {{(SAMPLE_BITS-1){1'b0}}, i2s_data_i};
                bit_cnt_q <= CW'(1);
                chan_q    <= i2s_lrclk_i;
                synced_q  <= 1'b1;
                state_q   <= SHIFT;
            end else if (rise && state_q == SHIFT) begin
                shift_q   <= {shift_q[SAMPLE_BITS-2:0], i2s_data_i};
                bit_cnt_q <= bit_cnt_q + CW'(1);
                if (bit_cnt_q == LAST_BIT) state_q <= PAD;
            end else if (rise && state_q == PAD) begin
                if (bit_cnt_q == SLOT_END) begin
                    err_q    <= 1'b1;
                    synced_q <= 1'b0;
                    state_q  <= HUNT;
                end else begin
                    bit_cnt_q <= bit_cnt_q + CW'(1);
                end
            end
        end
    end
    // FIFO pointers, held head value and sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            hold_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wr_q <= wr_q + {{FIFO_DEPTH_BITS{1'b0}}, write};
            rd_q <= rd_q + {{FIFO_DEPTH_BITS{1'b0}}, rd_adv};
            if (!empty) hold_q <= head;
            if (drop) ovf_q <= 1'b1;
        end
    end
    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (write) mem_q[wr_q[FIFO_DEPTH_BITS-1:0]] <= push_word;
    end
endmodule
